// File: rtl/single_port_blockram_controller.sv
// Initiator-side controller for a single-port block RAM: clears every set after reset, then
// serialises client read/write requests onto the RAM pins and returns read data on a response port.
module single_port_blockram_controller #(
    parameter int SINGLE_ELEMENT_SIZE_IN_BITS = 64,
    parameter int NUMBER_SETS                 = 64,
    parameter int SET_PTR_WIDTH_IN_BITS       = $clog2(NUMBER_SETS)
) (
    input  logic                                   clk_in,
    input  logic                                   reset_in,
    input  logic                                   request_valid_in,
    input  logic                                   request_write_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]       request_addr_in,
    input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] request_data_in,
    output logic                                   request_ready_out,
    output logic                                   response_valid_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]       response_addr_out,
    output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] response_data_out,
    output logic                                   response_error_out,
    input  logic                                   response_ready_in,
    output logic                                   init_done_out,
    output logic                                   ram_access_en_out,
    output logic                                   ram_write_en_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]       ram_set_addr_out,
    output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] ram_write_element_out,
    input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] ram_read_element_in
);

    localparam int AW = SET_PTR_WIDTH_IN_BITS;
    localparam int DW = SINGLE_ELEMENT_SIZE_IN_BITS;
    // The init pointer is one bit wider so it can reach NUMBER_SETS itself.
    localparam logic [AW:0] SET_COUNT = (AW+1)'(NUMBER_SETS);
    localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);

    typedef enum logic [2:0] {
        ST_INIT      = 3'd0,
        ST_IDLE      = 3'd1,
        ST_ISSUE_WR  = 3'd2,
        ST_ISSUE_RD  = 3'd3,
        ST_WAIT_DATA = 3'd4,
        ST_RESP      = 3'd5
    } state_t;

    function automatic logic addr_out_of_range(input logic [AW-1:0] addr);
        return ({1'b0, addr} >= SET_COUNT);
    endfunction

    state_t          state_r, state_nxt_s;
    logic [AW:0]     init_ptr_r, init_ptr_nxt_s;
    logic [AW-1:0]   req_addr_r, req_addr_nxt_s;
    logic            req_err_r, req_err_nxt_s;
    logic            req_ready_r, req_ready_nxt_s;
    logic            resp_valid_r, resp_valid_nxt_s;
    logic [AW-1:0]   resp_addr_r, resp_addr_nxt_s;
    logic [DW-1:0]   resp_data_r, resp_data_nxt_s;
    logic            resp_err_r, resp_err_nxt_s;
    logic            init_done_r, init_done_nxt_s;
    logic            ram_en_r, ram_en_nxt_s;
    logic            ram_we_r, ram_we_nxt_s;
    logic [AW-1:0]   ram_addr_r, ram_addr_nxt_s;
    logic [DW-1:0]   ram_wdata_r, ram_wdata_nxt_s;
    logic            req_oob_s;

    assign req_oob_s = addr_out_of_range(request_addr_in);

    // Next-state and next-output decode; RAM strobes default low, address/data pins hold.
    always_comb begin
        state_nxt_s      = state_r;
        init_ptr_nxt_s   = init_ptr_r;
        req_addr_nxt_s   = req_addr_r;
        req_err_nxt_s    = req_err_r;
        req_ready_nxt_s  = 1'b0;
        resp_valid_nxt_s = resp_valid_r;
        resp_addr_nxt_s  = resp_addr_r;
        resp_data_nxt_s  = resp_data_r;
        resp_err_nxt_s   = resp_err_r;
        init_done_nxt_s  = init_done_r;
        ram_en_nxt_s     = 1'b0;
        ram_we_nxt_s     = 1'b0;
        ram_addr_nxt_s   = ram_addr_r;
        ram_wdata_nxt_s  = ram_wdata_r;
        case (state_r)
            ST_INIT: begin
                if (init_ptr_r < SET_COUNT) begin
                    ram_en_nxt_s    = 1'b1;
                    ram_we_nxt_s    = 1'b1;
                    ram_addr_nxt_s  = init_ptr_r[AW-1:0];
                    ram_wdata_nxt_s = {DW{1'b0}};
                    init_ptr_nxt_s  = init_ptr_r + PTR_ONE;
                end else begin
                    init_done_nxt_s = 1'b1;
                    req_ready_nxt_s = 1'b1;
                    state_nxt_s     = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (request_valid_in && req_ready_r) begin
                    req_addr_nxt_s = request_addr_in;
                    req_err_nxt_s  = req_oob_s;
                    if (request_write_in) begin
                        state_nxt_s = ST_ISSUE_WR;
                    end else begin
                        state_nxt_s = ST_ISSUE_RD;
                    end
                    // An out-of-range request still walks the FSM but never touches the RAM.
                    if (!req_oob_s) begin
                        ram_en_nxt_s   = 1'b1;
                        ram_we_nxt_s   = request_write_in;
                        ram_addr_nxt_s = request_addr_in;
                        if (request_write_in) begin
                            ram_wdata_nxt_s = request_data_in;
                        end else begin
                            ram_wdata_nxt_s = ram_wdata_r;
                        end
                    end else begin
                        ram_en_nxt_s = 1'b0;
                    end
                end else begin
                    req_ready_nxt_s = 1'b1;
                end
            end
            ST_ISSUE_WR: begin
                req_ready_nxt_s = 1'b1;
                state_nxt_s     = ST_IDLE;
            end
            ST_ISSUE_RD: begin
                state_nxt_s = ST_WAIT_DATA;
            end
            ST_WAIT_DATA: begin
                resp_valid_nxt_s = 1'b1;
                resp_addr_nxt_s  = req_addr_r;
                resp_err_nxt_s   = req_err_r;
                if (req_err_r) begin
                    resp_data_nxt_s = {DW{1'b0}};
                end else begin
                    resp_data_nxt_s = ram_read_element_in;
                end
                state_nxt_s = ST_RESP;
            end
            ST_RESP: begin
                if (response_ready_in) begin
                    resp_valid_nxt_s = 1'b0;
                    req_ready_nxt_s  = 1'b1;
                    state_nxt_s      = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                init_ptr_nxt_s = {(AW+1){1'b0}};
                state_nxt_s    = ST_INIT;
            end
        endcase
    end

    // State and registered outputs; reset restarts the clear sequence from set 0.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_r      <= ST_INIT;
            init_ptr_r   <= {(AW+1){1'b0}};
            req_addr_r   <= {AW{1'b0}};
            req_err_r    <= 1'b0;
            req_ready_r  <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_addr_r  <= {AW{1'b0}};
            resp_data_r  <= {DW{1'b0}};
            resp_err_r   <= 1'b0;
            init_done_r  <= 1'b0;
            ram_en_r     <= 1'b0;
            ram_we_r     <= 1'b0;
            ram_addr_r   <= {AW{1'b0}};
            ram_wdata_r  <= {DW{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            init_ptr_r   <= init_ptr_nxt_s;
            req_addr_r   <= req_addr_nxt_s;
            req_err_r    <= req_err_nxt_s;
            req_ready_r  <= req_ready_nxt_s;
            resp_valid_r <= resp_valid_nxt_s;
            resp_addr_r  <= resp_addr_nxt_s;
            resp_data_r  <= resp_data_nxt_s;
            resp_err_r   <= resp_err_nxt_s;
            init_done_r  <= init_done_nxt_s;
            ram_en_r     <= ram_en_nxt_s;
            ram_we_r     <= ram_we_nxt_s;
            ram_addr_r   <= ram_addr_nxt_s;
            ram_wdata_r  <= ram_wdata_nxt_s;
        end
    end

    assign request_ready_out     = req_ready_r;
    assign response_valid_out    = resp_valid_r;
    assign response_addr_out     = resp_addr_r;
    assign response_data_out     = resp_data_r;
    assign response_error_out    = resp_err_r;
    assign init_done_out         = init_done_r;
    assign ram_access_en_out     = ram_en_r;
    assign ram_write_en_out      = ram_we_r;
    assign ram_set_addr_out      = ram_addr_r;
    assign ram_write_element_out = ram_wdata_r;

endmodule

// File: tb/tb_single_port_blockram_controller.sv
// Bench for single_port_blockram_controller: two instances (64 and 48 sets) each with a behavioural
// RAM, driven by directed and random transactions checked against an array model of set contents.
module tb_single_port_blockram_controller;

    localparam int DW = 64;
    localparam int AW = 6;

    logic          clk;
    logic          rst        [2];
    logic          req_valid  [2];
    logic          req_write  [2];
    logic [AW-1:0] req_addr   [2];
    logic [DW-1:0] req_data   [2];
    logic          req_ready  [2];
    logic          resp_valid [2];
    logic [AW-1:0] resp_addr  [2];
    logic [DW-1:0] resp_data  [2];
    logic          resp_err   [2];
    logic          resp_ready [2];
    logic          init_done  [2];
    logic          ram_en     [2];
    logic          ram_we     [2];
    logic [AW-1:0] ram_addr   [2];
    logic [DW-1:0] ram_wdata  [2];

    logic [DW-1:0] model_mem [2][64];
    int            n_checks = 0;
    int            n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : unit
        logic [DW-1:0] mem [64];
        logic [DW-1:0] rd;

        single_port_blockram_controller #(
            .SINGLE_ELEMENT_SIZE_IN_BITS(DW),
            .NUMBER_SETS((g == 0) ? 64 : 48)
        ) dut (
            .clk_in               (clk),
            .reset_in             (rst[g]),
            .request_valid_in     (req_valid[g]),
            .request_write_in     (req_write[g]),
            .request_addr_in      (req_addr[g]),
            .request_data_in      (req_data[g]),
            .request_ready_out    (req_ready[g]),
            .response_valid_out   (resp_valid[g]),
            .response_addr_out    (resp_addr[g]),
            .response_data_out    (resp_data[g]),
            .response_error_out   (resp_err[g]),
            .response_ready_in    (resp_ready[g]),
            .init_done_out        (init_done[g]),
            .ram_access_en_out    (ram_en[g]),
            .ram_write_en_out     (ram_we[g]),
            .ram_set_addr_out     (ram_addr[g]),
            .ram_write_element_out(ram_wdata[g]),
            .ram_read_element_in  (rd)
        );

        // Single-port RAM: pins sampled on the edge, read data valid the following cycle.
        always @(posedge clk) begin
            if (ram_en[g]) begin
                if (ram_we[g]) mem[ram_addr[g]] <= ram_wdata[g];
                else           rd <= mem[ram_addr[g]];
            end
        end
    end

    function automatic int nsets(input int u);
        return (u == 0) ? 64 : 48;
    endfunction

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Expects rst[u]=1 on entry at a negedge; releases reset and follows the full clear sequence.
    task automatic init_sequence(input int u);
        check_value("rst_en",    64'(ram_en[u]),     64'd0);
        check_value("rst_ready", 64'(req_ready[u]),  64'd0);
        check_value("rst_done",  64'(init_done[u]),  64'd0);
        check_value("rst_valid", 64'(resp_valid[u]), 64'd0);
        rst[u] = 1'b0;
        for (int i = 0; i < nsets(u); i++) begin
            @(negedge clk);
            check_value("init_en",    64'(ram_en[u]),    64'd1);
            check_value("init_we",    64'(ram_we[u]),    64'd1);
            check_value("init_addr",  64'(ram_addr[u]),  64'(i));
            check_value("init_data",  ram_wdata[u],      64'd0);
            check_value("init_ready", 64'(req_ready[u]), 64'd0);
            check_value("init_done0", 64'(init_done[u]), 64'd0);
        end
        @(negedge clk);
        check_value("init_end_en", 64'(ram_en[u]),    64'd0);
        check_value("init_done1",  64'(init_done[u]), 64'd1);
        check_value("init_ready1", 64'(req_ready[u]), 64'd1);
        for (int i = 0; i < 64; i++) model_mem[u][i] = 64'd0;
    endtask

    task automatic wait_ready(input int u);
        int n = 0;
        while (!req_ready[u] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_value("ready_wait", 64'(req_ready[u]), 64'd1);
    endtask

    task automatic do_write(input int u, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        logic oob;
        oob = (int'(addr) >= nsets(u));
        wait_ready(u);
        req_valid[u] = 1'b1; req_write[u] = 1'b1; req_addr[u] = addr; req_data[u] = data;
        @(posedge clk);
        #1 req_valid[u] = 1'b0;
        @(negedge clk);
        check_value("wr_en",    64'(ram_en[u]),    {63'd0, !oob});
        check_value("wr_we",    64'(ram_we[u]),    {63'd0, !oob});
        check_value("wr_ready", 64'(req_ready[u]), 64'd0);
        if (!oob) begin
            check_value("wr_addr", 64'(ram_addr[u]), 64'(addr));
            check_value("wr_data", ram_wdata[u],     data);
            model_mem[u][addr] = data;
        end
        @(negedge clk);
        check_value("wr_end_en",    64'(ram_en[u]),    64'd0);
        check_value("wr_end_ready", 64'(req_ready[u]), 64'd1);
    endtask

    task automatic do_read(input int u, input logic [AW-1:0] addr, input int hold);
        logic          oob;
        logic [DW-1:0] exp_data;
        oob      = (int'(addr) >= nsets(u));
        exp_data = oob ? 64'd0 : model_mem[u][addr];
        wait_ready(u);
        req_valid[u] = 1'b1; req_write[u] = 1'b0; req_addr[u] = addr;
        req_data[u] = {$urandom, $urandom};
        @(posedge clk);
        #1 req_valid[u] = 1'b0;
        @(negedge clk);
        check_value("rd_en",     64'(ram_en[u]),     {63'd0, !oob});
        check_value("rd_we",     64'(ram_we[u]),     64'd0);
        check_value("rd_valid0", 64'(resp_valid[u]), 64'd0);
        if (!oob) check_value("rd_addr", 64'(ram_addr[u]), 64'(addr));
        @(negedge clk);
        check_value("rd_wait_en", 64'(ram_en[u]),     64'd0);
        check_value("rd_valid1",  64'(resp_valid[u]), 64'd0);
        @(negedge clk);
        check_value("rsp_valid", 64'(resp_valid[u]), 64'd1);
        check_value("rsp_data",  resp_data[u],       exp_data);
        check_value("rsp_addr",  64'(resp_addr[u]),  64'(addr));
        check_value("rsp_err",   64'(resp_err[u]),   {63'd0, oob});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_value("hold_valid", 64'(resp_valid[u]), 64'd1);
            check_value("hold_data",  resp_data[u],       exp_data);
            check_value("hold_ready", 64'(req_ready[u]),  64'd0);
        end
        resp_ready[u] = 1'b1;
        @(posedge clk);
        #1 resp_ready[u] = 1'b0;
        @(negedge clk);
        check_value("rsp_drop",  64'(resp_valid[u]), 64'd0);
        check_value("rsp_ready", 64'(req_ready[u]),  64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1; req_valid[u] = 1'b0; req_write[u] = 1'b0;
            req_addr[u] = '0; req_data[u] = '0; resp_ready[u] = 1'b0;
        end
        repeat (3) @(negedge clk);
        init_sequence(0);
        init_sequence(1);

        do_read(0, 6'd5, 0);
        do_write(0, 6'd63, 64'hFFFF_FFFF_0000_0000);
        do_read(0, 6'd63, 1);
        do_read(0, 6'd63, 10);

        do_write(1, 6'd47, 64'h0123_4567_89AB_CDEF);
        do_write(1, 6'd50, 64'hDEAD_BEEF_CAFE_F00D);
        do_read(1, 6'd50, 0);
        do_read(1, 6'd47, 0);

        for (int t = 0; t < 150; t++) begin
            int            u;
            logic [AW-1:0] a;
            u = int'($urandom_range(1, 0));
            a = (u == 0) ? AW'($urandom_range(15, 0)) : AW'($urandom_range(63, 40));
            repeat ($urandom_range(2, 0)) @(negedge clk);
            if ($urandom_range(1, 0) == 1) do_write(u, a, {$urandom, $urandom});
            else                           do_read(u, a, int'($urandom_range(3, 0)));
        end

        // Reset while a read waits for RAM data: everything aborts and the clear sequence repeats.
        do_write(0, 6'd7, 64'h5A5A_A5A5_1234_5678);
        wait_ready(0);
        req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 6'd7;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst[0] = 1'b1;
        #1;
        check_value("arst_en",    64'(ram_en[0]),     64'd0);
        check_value("arst_valid", 64'(resp_valid[0]), 64'd0);
        check_value("arst_data",  resp_data[0],       64'd0);
        check_value("arst_done",  64'(init_done[0]),  64'd0);
        @(negedge clk);
        check_value("arst_noresp", 64'(resp_valid[0]), 64'd0);
        init_sequence(0);
        do_read(0, 6'd7, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
